// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - bin, one bit per clock, LSB first.
// Optional signed-overflow flag is enabled with `define SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             w_ai;
  logic             w_bi;
  logic             w_diff;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  // Full-subtractor cell on the current bit position.
  always_comb begin
    w_ai         = r_a[r_cnt];
    w_bi         = r_b[r_cnt];
    w_diff       = w_ai ^ w_bi ^ r_borrow;
    w_borrow_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
    w_res_nxt    = {w_diff, r_res[WIDTH-1:1]};
    w_last       = (r_cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; new operands are taken in IDLE or DONE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, serial datapath and result hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_res    <= '0;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_res    <= w_res_nxt;
      r_borrow <= w_borrow_nxt;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_d    <= w_res_nxt;
        r_bout <= w_borrow_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Two's-complement overflow, captured with the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && r_state == S_SHIFT && w_last) begin
      r_ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
               (w_diff != r_a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign d    = r_d;
  assign bout = r_bout;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle bit-serial subtractor, the inverse operation of the team's ripple-carry adder chain. It computes D = A - B - bin using one full-subtractor cell and a borrow flop, processing one bit per clock, LSB first. It serves area-constrained datapaths that can tolerate WIDTH-cycle latency, using a start/done handshake.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready to accept (state IDLE or DONE)
a  input  WIDTH  minuend; sampled on the accepting edge
b  input  WIDTH  subtrahend; sampled on the accepting edge
bin  input  1  borrow-in; sampled on the accepting edge
busy  output  1  high while the operation is in progress (state SHIFT)
done  output  1  one-cycle pulse: result valid
d  output  WIDTH  difference; held from done until the next done
bout  output  1  borrow-out of MSB; held with d
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; busy=0, done=0, d=0, bout=0, ovf=0; internal operand, result, borrow and count registers all 0. Takes effect immediately on rst_n low, including mid-operation; any partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge -> latch a, b; borrow<=bin; cnt<=0; go to SHIFT. start=0 -> stay.
- SHIFT (busy=1): on each edge, for bit i=cnt:
  - diff_i = a_i ^ b_i ^ borrow
  - borrow <= (~a_i & b_i) | (~(a_i ^ b_i) & borrow)
  - Shift diff_i into the result register from the MSB side.
  - cnt increments.
  - At cnt==WIDTH-1: transfer the completed result to d and the final borrow to bout; go to DONE.
- DONE (busy=0, done=1 for exactly this cycle):
  - start=1 -> accept new operands as in IDLE; go to SHIFT. This gives back-to-back operation.
  - Otherwise go to IDLE.
- Latency: accepting edge E0; bits processed on edges E1..E(WIDTH); done high in the cycle after E(WIDTH). Throughput is one result per WIDTH+1 cycles.
- start while busy=1: ignored; latched operands are unaffected; no queueing.
- a, b, bin changes during SHIFT have no effect.
- Arithmetic: the result is modulo 2^WIDTH. bout=1 iff a < b + bin (unsigned).
- d and bout update only on the SHIFT->DONE transition. They are stable otherwise.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined: ovf is updated together with d. ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the latched operands. This is two's-complement overflow of A - B - bin. The value holds until the next done.
- Undefined: ovf is tied to 0 and no overflow logic is generated. The port is always present.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0, start pulse -> busy high 4 cycles; done pulse in 5th cycle after acceptance; d=6, bout=0.
- a=3, b=9, bin=0 -> d=0xA, bout=1; d/bout remain stable for 10 idle cycles after done.
- a=0, b=0, bin=1 -> d=0xF, bout=1. Then a=0xF, b=0xF, bin=0 -> d=0, bout=0.
- Start a=8, b=1; assert start with a=0, b=5 on 2nd busy cycle -> ignored, d=7, bout=0. Then assert start in the DONE cycle with a=5, b=2 -> no IDLE gap, next d=3.
- Start a=0xC, b=4; pull rst_n low mid-SHIFT (asynchronously, between edges) -> busy/done/d/bout/ovf drop to 0 immediately. After release, no done occurs without a new start.
- With SERIAL_SUB_OVF_EN: a=7, b=0xF (7 - (-1)) -> d=8, bout=1, ovf=1. a=2, b=1 -> ovf=0. Without the macro, ovf=0 for both cases.
